// File: rtl/cpu_issue_arbiter.sv
// Two-requester issue arbiter in front of a tiny accumulator CPU.
// Grants one instruction at a time (round-robin under contention), drives it
// into the CPU with load/step until the CPU reports execute, then presents the
// accumulator and flags as a response that is held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high (and ena is high). Producers hold valid and payload stable until
// that edge; ready never depends on anything but the current state and inputs.
module cpu_issue_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       req0_valid,
   input  logic [7:0] req0_instr,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_instr,
   output logic       req1_ready,
   output logic [7:0] cpu_instr,
   output logic       cpu_load,
   output logic       cpu_step,
   input  logic       cpu_exec,
   input  logic [3:0] cpu_acc,
   input  logic [2:0] cpu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_data,
   output logic [2:0] rsp_flags,
   output logic       rsp_err,
   output logic       halted,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_EXEC = 2'd1;
   localparam logic [1:0] S_SETTLE    = 2'd2;
   localparam logic [1:0] S_RESPOND   = 2'd3;

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;      // requester granted most recently
   logic [3:0] cnt_q, cnt_d;        // execute timeout counter
   logic [7:0] instr_q, instr_d;
   logic       id_q, id_d;
   logic [3:0] data_q, data_d;
   logic [2:0] flags_q, flags_d;
   logic       err_q, err_d;
   logic       halted_q, halted_d;

   logic       grant_any;
   logic       grant_id;

   // Pick a winner in IDLE; ena gates the grant so a visible ready always transfers.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (state_q == S_IDLE && ena && !cpu_flags[2]) begin
         if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_q;
         end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign req0_ready = grant_any && !grant_id;
   assign req1_ready = grant_any && grant_id;

   assign cpu_instr = instr_q;
   assign cpu_load  = (state_q == S_WAIT_EXEC);
   assign cpu_step  = (state_q == S_WAIT_EXEC);
   assign rsp_valid = (state_q == S_RESPOND);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_flags = flags_q;
   assign rsp_err   = err_q;
   assign halted    = halted_q;
   assign dbg_state = state_q;

   // Next-state and datapath; everything holds while ena is low.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      instr_d  = instr_q;
      id_d     = id_q;
      data_d   = data_q;
      flags_d  = flags_q;
      err_d    = err_q;
      halted_d = halted_q;
      if (ena) begin
         halted_d = cpu_flags[2];
         case (state_q)
            S_IDLE: begin
               if (grant_any) begin
                  instr_d = grant_id ? req1_instr : req0_instr;
                  id_d    = grant_id;
                  cnt_d   = 4'd0;
                  state_d = S_WAIT_EXEC;
               end
            end
            S_WAIT_EXEC: begin
               if (cpu_exec) begin
                  state_d = S_SETTLE;
               end else if (cnt_q == 4'd15) begin
                  // CPU never reached execute: report an error response.
                  state_d = S_RESPOND;
                  err_d   = 1'b1;
                  data_d  = 4'd0;
                  flags_d = cpu_flags;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_SETTLE: begin
               data_d  = cpu_acc;
               flags_d = cpu_flags;
               err_d   = 1'b0;
               state_d = S_RESPOND;
            end
            S_RESPOND: begin
               if (rsp_ready) begin
                  last_d  = id_q;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         cnt_q    <= 4'd0;
         instr_q  <= 8'd0;
         id_q     <= 1'b0;
         data_q   <= 4'd0;
         flags_q  <= 3'd0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         id_q     <= id_d;
         data_q   <= data_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
         halted_q <= halted_d;
      end
   end

endmodule

// File: tb/tb_cpu_issue_arbiter.sv
// Bench for cpu_issue_arbiter: queue-driven requesters, a small behavioural CPU,
// and a monitor that predicts grants and responses from the arbitration rules.
`timescale 1ns/1ps
module tb_cpu_issue_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   always #5 clk = ~clk;

   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_instr = 8'd0, req1_instr = 8'd0;
   logic       req0_ready, req1_ready;
   logic [7:0] cpu_instr;
   logic       cpu_load, cpu_step;
   logic       cpu_exec = 1'b0;
   logic [3:0] cpu_acc = 4'd0;
   logic [2:0] cpu_flags = 3'd0;
   logic       rsp_valid, rsp_id, rsp_err, halted;
   logic       rsp_ready = 1'b1;
   logic [3:0] rsp_data;
   logic [2:0] rsp_flags;
   logic [1:0] dbg_state;

   cpu_issue_arbiter dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
      .cpu_instr(cpu_instr), .cpu_load(cpu_load), .cpu_step(cpu_step),
      .cpu_exec(cpu_exec), .cpu_acc(cpu_acc), .cpu_flags(cpu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .halted(halted), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   initial forever begin @(posedge clk); cyc++; end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural CPU semantics: returns {halt, carry, acc}.
   function automatic logic [5:0] cpu_op(input logic [7:0] ins, input logic [3:0] acc,
                                         input logic c, input logic h);
      logic [4:0] s;
      logic [3:0] a;
      logic       cc, hh;
      a = acc; cc = c; hh = h;
      case (ins[3:0])
         4'h1: a = ins[7:4];
         4'h2: begin s = {1'b0, acc} + {1'b0, ins[7:4]}; a = s[3:0]; cc = s[4]; end
         4'hF: hh = 1'b1;
         default: ;
      endcase
      return {hh, cc, a};
   endfunction

   // ---------------- environment knobs ----------------
   logic exec_tie_low = 1'b0;
   logic rand_delay = 1'b0;
   int   fixed_delay = 3;
   int   cur_lat = 0;
   logic bp_hold = 1'b0;
   logic rand_rdy = 1'b0;

   // ---------------- requester drivers ----------------
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic hs0 = 1'b0, hs1 = 1'b0;

   initial forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
         q0.delete(); q1.delete(); hs0 = 1'b0; hs1 = 1'b0;
      end else begin
         if (hs0 && q0.size() > 0) void'(q0.pop_front());
         if (hs1 && q1.size() > 0) void'(q1.pop_front());
         hs0 = 1'b0; hs1 = 1'b0;
      end
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      req0_instr = req0_valid ? q0[0] : 8'($urandom);
      req1_instr = req1_valid ? q1[0] : 8'($urandom);
      rsp_ready  = bp_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
   end

   // ---------------- behavioural CPU ----------------
   int   cpu_cnt = -1;
   logic cpu_done = 1'b0;
   initial forever begin
      logic [5:0] r;
      @(negedge clk);
      if (!rst_n) begin
         cpu_cnt = -1; cpu_done = 1'b0; cpu_exec = 1'b0; cpu_acc = 4'd0; cpu_flags = 3'd0;
      end else begin
         cpu_exec = 1'b0;
         if (!cpu_load) cpu_done = 1'b0;
         if (cpu_cnt < 0 && cpu_load && !cpu_done && !exec_tie_low) begin
            check("cpu_step_with_load", cpu_step, 1'b1);
            cpu_cnt = rand_delay ? int'($urandom_range(0, 6)) : fixed_delay;
            cur_lat = cpu_cnt + 3;
         end
         if (cpu_cnt == 0) begin
            r = cpu_op(cpu_instr, cpu_acc, cpu_flags[1], cpu_flags[2]);
            cpu_acc   = r[3:0];
            cpu_flags = {r[5], r[4], (r[3:0] == 4'd0)};
            cpu_exec  = 1'b1;
            cpu_done  = 1'b1;
            cpu_cnt   = -1;
         end else if (cpu_cnt > 0) begin
            cpu_cnt--;
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [8:0] exp_q[$];   // {id, data[3:0], flags[2:0], err}
   logic       ref_busy = 1'b0, ref_last = 1'b1;
   logic [3:0] ref_acc = 4'd0;
   logic       ref_c = 1'b0, ref_z = 1'b0, ref_halt = 1'b0;
   int         grant_cyc = 0, exp_lat = 0;
   logic       saw_valid = 1'b0;
   logic [8:0] snap;

   initial forever begin
      logic       g0, g1, gid;
      logic [7:0] ins;
      logic [5:0] r;
      logic [8:0] e, got;
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete(); ref_busy = 1'b0; ref_last = 1'b1; saw_valid = 1'b0;
         ref_acc = 4'd0; ref_c = 1'b0; ref_z = 1'b0; ref_halt = 1'b0;
      end else begin
         if (!ref_busy) begin
            check("rsp_valid_idle", rsp_valid, 1'b0);
            check("cpu_load_idle", cpu_load, 1'b0);
            check("cpu_step_idle", cpu_step, 1'b0);
         end
         // Grant prediction: one transaction in flight, round-robin on contention.
         g0 = 1'b0; g1 = 1'b0;
         if (ena && !ref_busy && !ref_halt) begin
            if (req0_valid && req1_valid) begin g0 = ref_last; g1 = ~ref_last; end
            else begin g0 = req0_valid; g1 = req1_valid; end
         end
         check("req0_ready", req0_ready, g0);
         check("req1_ready", req1_ready, g1);
         if (req0_valid && req0_ready) hs0 = 1'b1;
         if (req1_valid && req1_ready) hs1 = 1'b1;
         if (g0 || g1) begin
            gid = g1;
            ins = gid ? req1_instr : req0_instr;
            if (exec_tie_low) begin
               e = {gid, 4'd0, ref_halt, ref_c, ref_z, 1'b1};
               exp_lat = 17;
            end else begin
               r = cpu_op(ins, ref_acc, ref_c, ref_halt);
               ref_acc = r[3:0]; ref_c = r[4]; ref_halt = r[5]; ref_z = (r[3:0] == 4'd0);
               e = {gid, ref_acc, ref_halt, ref_c, ref_z, 1'b0};
               exp_lat = -1;
            end
            exp_q.push_back(e);
            ref_busy = 1'b1; ref_last = gid; grant_cyc = cyc; saw_valid = 1'b0;
         end else if (ref_busy && rsp_valid) begin
            got = {rsp_id, rsp_data, rsp_flags, rsp_err};
            if (!saw_valid) begin
               saw_valid = 1'b1;
               snap = got;
               check("latency", cyc - grant_cyc, (exp_lat < 0) ? cur_lat : exp_lat);
            end else begin
               check("rsp_stable", got, snap);
            end
            if (rsp_ready && ena) begin
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_id", got[8], e[8]);
                  check("rsp_data", got[7:4], e[7:4]);
                  check("rsp_flags", got[3:1], e[3:1]);
                  check("rsp_err", got[0], e[0]);
               end
               ref_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_req0_ready"}, req0_ready, 1'b0);
      check({tag, "_req1_ready"}, req1_ready, 1'b0);
      check({tag, "_cpu_instr"}, cpu_instr, 8'd0);
      check({tag, "_cpu_load"}, cpu_load, 1'b0);
      check({tag, "_cpu_step"}, cpu_step, 1'b0);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_id"}, rsp_id, 1'b0);
      check({tag, "_rsp_data"}, rsp_data, 4'd0);
      check({tag, "_rsp_flags"}, rsp_flags, 3'd0);
      check({tag, "_rsp_err"}, rsp_err, 1'b0);
      check({tag, "_halted"}, halted, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero_outputs(tag);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_drained(input string tag, input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || ref_busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, (n < budget), 1'b1);
      tick();
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!ref_busy && n < 50) begin tick(); n++; end
      check({tag, "_granted"}, (n < 50), 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [22:0] frz;
      int n;
      #2;
      do_reset("reset");

      // Contention straight after reset: grants must go 0,1,0,1,...
      for (int i = 0; i < 3; i++) begin q0.push_back(8'h31); q1.push_back(8'h22); end
      wait_drained("contention", 400);

      // Single issue: LOAD 5 from req0.
      fixed_delay = 3;
      q0.push_back(8'h51);
      wait_drained("single", 100);

      // Back-pressure: response held 10 cycles while another request waits.
      bp_hold = 1'b1;
      q1.push_back(8'hC2);
      n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      check("bp_rsp_seen", (n < 100), 1'b1);
      q0.push_back(8'h31);
      repeat (10) tick();
      bp_hold = 1'b0;
      wait_drained("backpressure", 200);

      // Random traffic with random CPU delay and random consumer readiness.
      rand_delay = 1'b1;
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] ins;
         ins = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
         if ($urandom_range(0, 1) == 0) begin
            if (q0.size() < 3) q0.push_back(ins);
         end else begin
            if (q1.size() < 3) q1.push_back(ins);
         end
         repeat ($urandom_range(0, 4)) tick();
      end
      wait_drained("random", 3000);
      rand_delay = 1'b0;
      rand_rdy = 1'b0;

      // Timeout: CPU never reaches execute.
      exec_tie_low = 1'b1;
      q1.push_back(8'h71);
      wait_drained("timeout", 100);
      exec_tie_low = 1'b0;

      // ena low for 5 cycles mid-transaction: everything frozen.
      fixed_delay = 10;
      q0.push_back(8'h91);
      wait_busy("ena");
      tick();
      tick();
      ena = 1'b0;
      frz = {cpu_instr, cpu_load, cpu_step, rsp_valid, rsp_id, rsp_data, rsp_flags,
             rsp_err, halted, req0_ready, req1_ready};
      q1.push_back(8'h22);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ena_frozen", {cpu_instr, cpu_load, cpu_step, rsp_valid, rsp_id, rsp_data,
                              rsp_flags, rsp_err, halted, req0_ready, req1_ready}, frz);
      end
      tick();
      ena = 1'b1;
      wait_drained("ena", 200);

      // HALT: response carries halt flag, then no further grants.
      fixed_delay = 2;
      q0.push_back(8'h0F);
      wait_drained("halt", 100);
      repeat (2) tick();
      check("halted", halted, 1'b1);
      q1.push_back(8'h22);
      repeat (30) tick();
      check("halt_no_grant_q1", q1.size(), 1);
      check("halt_req1_ready", req1_ready, 1'b0);

      // Reset clears halt; then reset again in the middle of WAIT_EXEC.
      do_reset("reset2");
      fixed_delay = 8;
      q0.push_back(8'h51);
      wait_busy("midreset");
      tick();
      tick();
      check("midreset_cpu_load", cpu_load, 1'b1);
      do_reset("reset3");
      q0.push_back(8'h31);
      q1.push_back(8'h22);
      fixed_delay = 1;
      wait_drained("after_reset", 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
